// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with exact occupancy count, registered status flags,
// sticky overflow/underflow error flags and synchronous flush.
module sync_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = 6,
   parameter int AE_THRESH = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           data_out,
   output logic                       rd_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_acc;
   logic             rd_acc;
   logic             wr_rej;
   logic             rd_rej;
   logic [CW-1:0]    count_nxt;

   // Acceptance uses the registered full/empty from before the edge; flush masks everything.
   always_comb begin
      wr_acc = wr_en && !full  && !flush;
      rd_acc = rd_en && !empty && !flush;
      wr_rej = wr_en &&  full  && !flush;
      rd_rej = rd_en &&  empty && !flush;
   end

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (wr_acc && !rd_acc)
         count_nxt = count + CW'(1);
      else if (rd_acc && !wr_acc)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         data_out     <= '0;
         rd_valid     <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_acc)
               wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) begin
               rd_ptr   <= rd_ptr + AW'(1);
               data_out <= mem[rd_ptr];
            end
         end
         rd_valid     <= rd_acc;
         count        <= count_nxt;
         full         <= (count_nxt == CW'(DEPTH));
         empty        <= (count_nxt == '0);
         almost_full  <= (count_nxt >= CW'(AF_THRESH));
         almost_empty <= (count_nxt <= CW'(AE_THRESH));
         // A new rejection in the same cycle as clr_err keeps the flag set.
         if (wr_rej)
            overflow <= 1'b1;
         else if (clr_err)
            overflow <= 1'b0;
         if (rd_rej)
            underflow <= 1'b1;
         else if (clr_err)
            underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1)
// with hand-computed expected values checked by immediate assertions.
module tb_sync_fifo_param;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       wr_en;
   logic [7:0] data_in;
   logic       rd_en;
   logic [7:0] data_out;
   logic       rd_valid;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic       overflow;
   logic       underflow;
   logic       clr_err;

   int vectors;
   int miscompares;

   sync_fifo_param #(
      .WIDTH(8),
      .DEPTH(8),
      .AF_THRESH(6),
      .AE_THRESH(1)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .wr_en(wr_en),
      .data_in(data_in),
      .rd_en(rd_en),
      .data_out(data_out),
      .rd_valid(rd_valid),
      .count(count),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .overflow(overflow),
      .underflow(underflow),
      .clr_err(clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_empty"}, 32'(empty), 1);
      chk({tag, "_full"}, 32'(full), 0);
      chk({tag, "_af"}, 32'(almost_full), 0);
      chk({tag, "_ae"}, 32'(almost_empty), 1);
      chk({tag, "_dout"}, 32'(data_out), 0);
      chk({tag, "_rdv"}, 32'(rd_valid), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
      chk({tag, "_unf"}, 32'(underflow), 0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n   = 1'b0;
      flush   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      data_in = '0;
      #12;
      chk_reset_state("reset");
      rst_n = 1'b1;

      // Fill with 0x11..0x88
      for (int i = 0; i < 8; i++) begin
         wr_en   = 1'b1;
         data_in = 8'((i + 1) * 17);
         tick();
         chk("fill_count", 32'(count), 32'(i + 1));
         chk("fill_af", 32'(almost_full), 32'((i + 1) >= 6));
         chk("fill_full", 32'(full), 32'(i == 7));
         chk("fill_empty", 32'(empty), 0);
         chk("fill_ae", 32'(almost_empty), 32'((i + 1) <= 1));
      end

      // Write while full is rejected
      data_in = 8'hEE;
      tick();
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_count", 32'(count), 8);
      chk("ovf_full", 32'(full), 1);
      wr_en   = 1'b0;
      clr_err = 1'b1;
      tick();
      chk("ovf_clr", 32'(overflow), 0);
      clr_err = 1'b0;

      // Drain in order; 0xEE must never appear
      for (int i = 0; i < 8; i++) begin
         rd_en = 1'b1;
         tick();
         chk("drain_data", 32'(data_out), 32'((i + 1) * 17));
         chk("drain_rdv", 32'(rd_valid), 1);
         chk("drain_count", 32'(count), 32'(7 - i));
         chk("drain_empty", 32'(empty), 32'(i == 7));
      end

      // Read on empty
      tick();
      chk("unf_set", 32'(underflow), 1);
      chk("unf_rdv", 32'(rd_valid), 0);
      chk("unf_dout_hold", 32'(data_out), 32'h88);
      chk("unf_count", 32'(count), 0);
      rd_en   = 1'b0;
      clr_err = 1'b1;
      tick();
      chk("unf_clr", 32'(underflow), 0);
      clr_err = 1'b0;

      // Prime to count 4 with 1..4, then 20 cycles of simultaneous read/write
      for (int i = 0; i < 4; i++) begin
         wr_en   = 1'b1;
         data_in = 8'(i + 1);
         tick();
      end
      chk("prime_count", 32'(count), 4);
      rd_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         data_in = 8'(k + 5);
         tick();
         chk("rw_count", 32'(count), 4);
         chk("rw_data", 32'(data_out), 32'(k + 1));
         chk("rw_rdv", 32'(rd_valid), 1);
      end
      rd_en   = 1'b0;
      data_in = 8'd25;
      tick();
      chk("pre_flush_count", 32'(count), 5);

      // Flush with a concurrent write
      flush   = 1'b1;
      data_in = 8'hAB;
      tick();
      chk("flush_count", 32'(count), 0);
      chk("flush_empty", 32'(empty), 1);
      chk("flush_ae", 32'(almost_empty), 1);
      chk("flush_af", 32'(almost_full), 0);
      chk("flush_rdv", 32'(rd_valid), 0);
      chk("flush_dout_hold", 32'(data_out), 32'h14);
      chk("flush_no_err", 32'({overflow, underflow}), 0);
      flush   = 1'b0;
      data_in = 8'h5A;
      tick();
      chk("post_flush_count", 32'(count), 1);
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
      chk("post_flush_data", 32'(data_out), 32'h5A);
      chk("post_flush_empty", 32'(empty), 1);

      // Empty + write + read: write wins, underflow set
      wr_en   = 1'b1;
      data_in = 8'h77;
      tick();
      chk("ewr_count", 32'(count), 1);
      chk("ewr_unf", 32'(underflow), 1);
      chk("ewr_rdv", 32'(rd_valid), 0);
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      for (int i = 0; i < 7; i++) begin
         wr_en   = 1'b1;
         data_in = 8'(8'h80 + i);
         tick();
      end
      chk("refill_full", 32'(full), 1);

      // Full + write + read: read wins, overflow set
      rd_en   = 1'b1;
      data_in = 8'h99;
      tick();
      chk("fwr_count", 32'(count), 7);
      chk("fwr_ovf", 32'(overflow), 1);
      chk("fwr_data", 32'(data_out), 32'h77);
      chk("fwr_full", 32'(full), 0);
      rd_en   = 1'b0;
      data_in = 8'h9A;
      tick();
      chk("refull", 32'(full), 1);

      // Rejected write and clr_err together: set wins
      clr_err = 1'b1;
      tick();
      chk("set_wins", 32'(overflow), 1);
      wr_en = 1'b0;
      tick();
      chk("clr_after", 32'(overflow), 0);
      clr_err = 1'b0;

      // Reset mid-burst at count 3 with a read in flight
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wr_en   = 1'b1;
         data_in = 8'(8'hA0 + i);
         tick();
      end
      chk("burst_count", 32'(count), 3);
      wr_en = 1'b0;
      rd_en = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_state("midrst");
      rd_en = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
      chk("midrst_held", 32'(rd_valid), 0);
      wr_en   = 1'b1;
      data_in = 8'hC3;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
      chk("midrst_data", 32'(data_out), 32'hC3);
      chk("midrst_rdv", 32'(rd_valid), 1);
      chk("midrst_count", 32'(count), 0);
      rd_en = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
